// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//   Test-pattern generator sitting between the VGA timing core and the pad
//   mux. Takes the raster position and syncs from the timing core and emits
//   registered RGB together with de/hsync/vsync, all delayed by the same two
//   register stages (stage 1 = compute, stage 2 = output).
//
//   Patterns (selected by a mode latch that only changes at frame start):
//     0  scrolling gradient : r ramps along x (scrolled), g ramps along y,
//                             b = MAX - r
//     1  colour bars        : eight vertical bars, white .. black
//     2  checkerboard       : 2**CHK_SHIFT squares, scrolled along x
//     3  solid colour       : solid_rgb
//
//   Frame start is detected in the clk domain as an inactive->active edge on
//   vsync_in; nothing is clocked by vsync.
//
// Ports
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   x_in       in   current pixel column
//   y_in       in   current line
//   de_in      in   active-video enable
//   hsync_in   in   horizontal sync from timing core
//   vsync_in   in   vertical sync from timing core
//   mode       in   pattern select, latched at frame start
//   speed      in   scroll step in pixels per frame
//   freeze     in   1 = hold the scroll offset
//   solid_rgb  in   {r,g,b} used by mode 3
//   r_o/g_o/b_o out colour outputs (0 whenever de_o = 0)
//   de_o       out  de_in delayed two cycles
//   hsync_o    out  hsync_in delayed two cycles
//   vsync_o    out  vsync_in delayed two cycles
//   frame_cnt  out  frames since reset (wraps)
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int   CW        = 4,
    parameter int   XW        = 11,
    parameter int   YW        = 11,
    parameter int   H_ACTIVE  = 640,
    parameter int   V_ACTIVE  = 480,
    parameter int   SPEED_W   = 4,
    parameter int   CHK_SHIFT = 5,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XW-1:0]     x_in,
    input  logic [YW-1:0]     y_in,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [1:0]        mode,
    input  logic [SPEED_W-1:0] speed,
    input  logic              freeze,
    input  logic [3*CW-1:0]   solid_rgb,
    output logic [CW-1:0]     r_o,
    output logic [CW-1:0]     g_o,
    output logic [CW-1:0]     b_o,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [15:0]       frame_cnt
);

    localparam logic [CW-1:0] MAX_C      = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};
    localparam int            RAMP_STEPS = (32'sd1 <<< CW) - 32'sd1;
    localparam int            BAR_W      = H_ACTIVE / 32'sd8;

    // ramp(p, n) = floor(p * 2**CW / n), built as a sum of comparisons against
    // the constant thresholds k*n so no divider is needed: the result is the
    // number of k in 1..MAX with k*n <= p*2**CW.
    function automatic logic [CW-1:0] ramp(input logic [31:0] p, input int n);
        logic [CW-1:0] acc;
        acc = '0;
        for (int k = 1; k <= RAMP_STEPS; k++) begin
            if ((p << CW) >= 32'(k * n)) begin
                acc = acc + ONE_C;
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // -----------------------------------------------------------------------
    // Frame-level state
    // -----------------------------------------------------------------------
    logic              vs_act_s;
    logic              vs_act_prev_r;
    logic              fs_s;
    logic [XW-1:0]     offset_r;
    logic [1:0]        mode_r;
    logic [15:0]       frame_cnt_r;
    logic [XW:0]       off_sum_s;
    logic [XW-1:0]     off_next_s;

    assign vs_act_s = (vsync_in == VSYNC_POL);
    assign fs_s     = vs_act_s & ~vs_act_prev_r;

    // Next scroll offset: offset + speed, wrapped once into 0..H_ACTIVE-1
    always_comb begin
        off_sum_s = {1'b0, offset_r} + (XW+1)'(speed);
        if (off_sum_s >= (XW+1)'(H_ACTIVE)) begin
            off_next_s = XW'(off_sum_s - (XW+1)'(H_ACTIVE));
        end else begin
            off_next_s = off_sum_s[XW-1:0];
        end
    end

    // Frame-start bookkeeping: counter, mode latch and scroll offset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_prev_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
            mode_r        <= 2'd0;
            offset_r      <= '0;
        end else begin
            vs_act_prev_r <= vs_act_s;
            if (fs_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
                mode_r      <= mode;
                if (!freeze) begin
                    offset_r <= off_next_s;
                end else begin
                    offset_r <= offset_r;
                end
            end else begin
                frame_cnt_r <= frame_cnt_r;
                mode_r      <= mode_r;
                offset_r    <= offset_r;
            end
        end
    end

    assign frame_cnt = frame_cnt_r;

    // -----------------------------------------------------------------------
    // Stage 1: pixel colour computation
    // -----------------------------------------------------------------------
    logic [XW-1:0] x_c_s;
    logic [YW-1:0] y_c_s;
    logic [XW:0]   x_sum_s;
    logic [XW-1:0] px_s;
    logic [2:0]    bar_s;
    logic [2:0]    bar_rgb_s;
    logic          chk_s;
    logic [CW-1:0] r_s;
    logic [CW-1:0] g_s;
    logic [CW-1:0] b_s;

    // Coordinates outside the active area are clamped to the last pixel/line
    always_comb begin
        if (x_in >= XW'(H_ACTIVE)) begin
            x_c_s = XW'(H_ACTIVE - 32'sd1);
        end else begin
            x_c_s = x_in;
        end
        if (y_in >= YW'(V_ACTIVE)) begin
            y_c_s = YW'(V_ACTIVE - 32'sd1);
        end else begin
            y_c_s = y_in;
        end
    end

    // Scrolled column: the raw sum feeds the checker, the wrapped one the ramp
    always_comb begin
        x_sum_s = {1'b0, x_c_s} + {1'b0, offset_r};
        if (x_sum_s >= (XW+1)'(H_ACTIVE)) begin
            px_s = XW'(x_sum_s - (XW+1)'(H_ACTIVE));
        end else begin
            px_s = x_sum_s[XW-1:0];
        end
    end

    // Bar index = x / (H_ACTIVE/8), as a count of passed bar boundaries
    always_comb begin
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (32'(x_c_s) >= 32'(k * BAR_W)) begin
                bar_s = bar_s + 3'd1;
            end else begin
                bar_s = bar_s;
            end
        end
    end

    // Bar colour table, {r,g,b} on/off
    always_comb begin
        case (bar_s)
            3'd0:    bar_rgb_s = 3'b111; // white
            3'd1:    bar_rgb_s = 3'b110; // yellow
            3'd2:    bar_rgb_s = 3'b011; // cyan
            3'd3:    bar_rgb_s = 3'b010; // green
            3'd4:    bar_rgb_s = 3'b101; // magenta
            3'd5:    bar_rgb_s = 3'b100; // red
            3'd6:    bar_rgb_s = 3'b001; // blue
            default: bar_rgb_s = 3'b000; // black
        endcase
    end

    // Checker parity: bit CHK_SHIFT of the scrolled column xor of the line
    assign chk_s = x_sum_s[CHK_SHIFT] ^ y_c_s[CHK_SHIFT];

    // Pattern select on the latched mode
    always_comb begin
        r_s = '0;
        g_s = '0;
        b_s = '0;
        case (mode_r)
            2'd0: begin
                r_s = ramp(32'(px_s), H_ACTIVE);
                g_s = ramp(32'(y_c_s), V_ACTIVE);
                b_s = MAX_C - r_s;
            end
            2'd1: begin
                r_s = {CW{bar_rgb_s[2]}};
                g_s = {CW{bar_rgb_s[1]}};
                b_s = {CW{bar_rgb_s[0]}};
            end
            2'd2: begin
                r_s = {CW{chk_s}};
                g_s = {CW{chk_s}};
                b_s = {CW{chk_s}};
            end
            2'd3: begin
                r_s = solid_rgb[3*CW-1 -: CW];
                g_s = solid_rgb[2*CW-1 -: CW];
                b_s = solid_rgb[CW-1:0];
            end
            default: begin
                r_s = '0;
                g_s = '0;
                b_s = '0;
            end
        endcase
    end

    logic          de_s1_r;
    logic          hs_s1_r;
    logic          vs_s1_r;
    logic [CW-1:0] r_s1_r;
    logic [CW-1:0] g_s1_r;
    logic [CW-1:0] b_s1_r;

    // Stage 1 register: computed colour plus delayed timing signals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_s1_r <= 1'b0;
            hs_s1_r <= ~HSYNC_POL;
            vs_s1_r <= ~VSYNC_POL;
            r_s1_r  <= '0;
            g_s1_r  <= '0;
            b_s1_r  <= '0;
        end else begin
            de_s1_r <= de_in;
            hs_s1_r <= hsync_in;
            vs_s1_r <= vsync_in;
            r_s1_r  <= r_s;
            g_s1_r  <= g_s;
            b_s1_r  <= b_s;
        end
    end

    // Stage 2 register: outputs, colour forced to black outside active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_o    <= 1'b0;
            hsync_o <= ~HSYNC_POL;
            vsync_o <= ~VSYNC_POL;
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
        end else begin
            de_o    <= de_s1_r;
            hsync_o <= hs_s1_r;
            vsync_o <= vs_s1_r;
            if (de_s1_r) begin
                r_o <= r_s1_r;
                g_o <= g_s1_r;
                b_o <= b_s1_r;
            end else begin
                r_o <= '0;
                g_o <= '0;
                b_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a driver issues pixels and pushes the expected
// colour of every active pixel into a queue; a negedge monitor pops it when
// de_o is seen and also checks the delayed timing signals and blanking.
module tb_vga_pattern_gen;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int CS = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x_in;
    logic [10:0] y_in;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [1:0]  mode;
    logic [3:0]  speed;
    logic        freeze;
    logic [11:0] solid_rgb;
    logic [3:0]  r_o;
    logic [3:0]  g_o;
    logic [3:0]  b_o;
    logic        de_o;
    logic        hsync_o;
    logic        vsync_o;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .speed(speed),
        .freeze(freeze), .solid_rgb(solid_rgb), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_cnt(frame_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    // reference model state
    int m_off;
    int m_mode;
    int m_frames;
    bit m_prev_act;
    logic [11:0] bar_tab [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                   12'hF0F, 12'hF00, 12'h00F, 12'h000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_pixel(input int x, input int y);
        int xc, yc, px, r, g;
        xc = (x >= H) ? H - 1 : x;
        yc = (y >= V) ? V - 1 : y;
        px = (xc + m_off) % H;
        case (m_mode)
            0: begin
                r = (px * 16) / H;
                g = (yc * 16) / V;
                return {4'(r), 4'(g), 4'(15 - r)};
            end
            1: return bar_tab[xc / (H / 8)];
            2: return ((((xc + m_off) >> CS) ^ (yc >> CS)) & 1) != 0 ? 12'hFFF : 12'h000;
            default: return solid_rgb;
        endcase
    endfunction

    task automatic model_reset();
        m_off = 0; m_mode = 0; m_frames = 0; m_prev_act = 1'b0;
        exp_q.delete();
    endtask

    // Drive one pixel clock worth of inputs and advance the model
    task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
        bit act;
        x_in = 11'(x); y_in = 11'(y); de_in = de; hsync_in = hs; vsync_in = vs;
        if (de) exp_q.push_back(model_pixel(x, y));
        act = (vs == 1'b0);
        if (act && !m_prev_act) begin
            m_frames++;
            m_mode = int'(mode);
            if (!freeze) m_off = (m_off + int'(speed)) % H;
        end
        m_prev_act = act;
        @(posedge clk); #1;
    endtask

    task automatic frame_pulse(input int new_mode);
        mode = 2'(new_mode);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic check_reset_vals();
        chk("rst_r", 32'(r_o), 32'd0);
        chk("rst_g", 32'(g_o), 32'd0);
        chk("rst_b", 32'(b_o), 32'd0);
        chk("rst_de", 32'(de_o), 32'd0);
        chk("rst_hs", 32'(hsync_o), 32'd1);
        chk("rst_vs", 32'(vsync_o), 32'd1);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    endtask

    // Assert reset between edges and check outputs before any clock edge
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // monitor: two-deep history of the timing inputs
    logic [1:0] h_de, h_hs, h_vs;
    int hist_n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_n <= 0;
            h_de <= 2'b00; h_hs <= 2'b11; h_vs <= 2'b11;
        end else begin
            h_de <= {h_de[0], de_in};
            h_hs <= {h_hs[0], hsync_in};
            h_vs <= {h_vs[0], vsync_in};
            if (hist_n < 2) hist_n <= hist_n + 1;
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n && hist_n >= 2) begin
            chk("de_o", 32'(de_o), 32'(h_de[1]));
            chk("hsync_o", 32'(hsync_o), 32'(h_hs[1]));
            chk("vsync_o", 32'(vsync_o), 32'(h_vs[1]));
            if (de_o) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rgb", 32'({r_o, g_o, b_o}), 32'(e));
                end
            end else begin
                chk("blank_rgb", 32'({r_o, g_o, b_o}), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        x_in = '0; y_in = '0; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        mode = 2'd0; speed = 4'd0; freeze = 1'b0; solid_rgb = 12'h000;
        model_reset();
        #12;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 0, 1'b0, 1'b1, 1'b1);

        // latency: mode 3 solid colour, single-cycle de pulse
        solid_rgb = 12'hA5C;
        frame_pulse(3);
        chk("fcnt_1", 32'(frame_cnt), 32'd1);
        step(10, 10, 1'b0, 1'b1, 1'b1);
        step(5, 5, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_de_early", 32'(de_o), 32'd0);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_de", 32'(de_o), 32'd1);
        chk("lat_rgb", 32'({r_o, g_o, b_o}), 32'h00000A5C);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_de_late", 32'(de_o), 32'd0);

        // reset in the middle of an active line
        step(1, 2, 1'b1, 1'b1, 1'b1);
        step(2, 2, 1'b1, 1'b0, 1'b1);
        reset_mid();

        // gradient with offset 0
        frame_pulse(0);
        step(639, 479, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b1, 1'b1, 1'b1);
        step(320, 240, 1'b1, 1'b1, 1'b1);
        step(100, 100, 1'b0, 1'b1, 1'b1);
        step(1000, 2000, 1'b1, 1'b1, 1'b1);

        // colour bars, then a deferred mode switch
        frame_pulse(1);
        step(0, 0, 1'b1, 1'b1, 1'b1);
        step(80, 0, 1'b1, 1'b1, 1'b1);
        step(79, 0, 1'b1, 1'b1, 1'b1);
        step(560, 0, 1'b1, 1'b1, 1'b1);
        step(639, 0, 1'b1, 1'b1, 1'b1);
        mode = 2'd2;
        step(0, 0, 1'b1, 1'b1, 1'b1);
        step(80, 0, 1'b1, 1'b1, 1'b1);

        // checkerboard
        frame_pulse(2);
        step(31, 0, 1'b1, 1'b1, 1'b1);
        step(32, 0, 1'b1, 1'b1, 1'b1);
        step(32, 32, 1'b1, 1'b1, 1'b1);
        step(700, 500, 1'b1, 1'b1, 1'b1);
        chk("fcnt_3", 32'(frame_cnt), 32'd3);

        // scrolling: 92 frames at speed 7
        reset_mid();
        speed = 4'd7;
        for (int i = 0; i < 92; i++) frame_pulse(0);
        chk("fcnt_92", 32'(frame_cnt), 32'd92);
        step(635, 0, 1'b1, 1'b1, 1'b1);
        step(636, 0, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b1, 1'b1, 1'b1);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) frame_pulse(0);
        step(635, 0, 1'b1, 1'b1, 1'b1);
        step(636, 0, 1'b1, 1'b1, 1'b1);
        chk("fcnt_95", 32'(frame_cnt), 32'd95);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) speed = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) freeze = 1'($urandom_range(0, 1));
            solid_rgb = 12'($urandom_range(0, 4095));
            step(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 19) != 0));
            if (i % 250 == 0) chk("fcnt_rand", 32'(frame_cnt), 32'(m_frames & 16'hFFFF));
        end

        repeat (4) step(0, 0, 1'b0, 1'b1, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("fcnt_final", 32'(frame_cnt), 32'(m_frames & 16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
